// File: rtl/trng_health_monitor.sv
// trng_health_monitor
// Online health tests for raw entropy words: a word-level repetition count
// test (RCT) and a bit-level adaptive proportion test (APT). Words seen during
// the startup windows are tested and dropped; afterwards passing words are
// forwarded through a single output register. Any failure latches a sticky
// alarm that only alarm_clr can release.
module trng_health_monitor #(
  parameter int WIDTH           = 32,
  parameter int RCT_CUTOFF      = 4,
  parameter int APT_WORDS       = 16,
  parameter int APT_LO          = 200,
  parameter int APT_HI          = 312,
  parameter int STARTUP_WINDOWS = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             alarm_clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             startup_done,
  output logic             rct_fail,
  output logic             apt_fail,
  output logic             alarm
);

  localparam int RW = $clog2(RCT_CUTOFF) + 1;
  localparam int OW = $clog2(APT_WORDS * WIDTH) + 1;
  localparam int IW = (APT_WORDS > 1) ? $clog2(APT_WORDS) : 1;
  localparam int SW = $clog2(STARTUP_WINDOWS + 1) + 1;

  localparam logic [RW-1:0] RCT_LIMIT  = RW'(RCT_CUTOFF);
  localparam logic [OW-1:0] APT_LO_W   = OW'(APT_LO);
  localparam logic [OW-1:0] APT_HI_W   = OW'(APT_HI);
  localparam logic [IW-1:0] WIN_LAST   = IW'(APT_WORDS - 1);
  localparam logic [SW-1:0] START_WINS = SW'(STARTUP_WINDOWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STARTUP,
    S_RUN,
    S_ALARM
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             have_last_q, have_last_d;
  logic [RW-1:0]    rc_q, rc_d;
  logic [IW-1:0]    win_idx_q, win_idx_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic [SW-1:0]    win_cnt_q, win_cnt_d;
  logic             startup_done_q, startup_done_d;
  logic             rct_fail_q, rct_fail_d;
  logic             apt_fail_q, apt_fail_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [OW-1:0]    word_ones;
  logic [OW-1:0]    ones_total;
  logic [RW-1:0]    rc_next;
  logic             win_last;
  logic             rct_hit;
  logic             apt_hit;
  logic             accept;
  logic             clear_ctx;

  // Number of ones in the incoming word, sized to the window accumulator.
  always_comb begin
    word_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_ones = word_ones + OW'(in_data[i]);
    end
  end

  // Health-test verdicts for the word currently on in_data, assuming it is accepted.
  always_comb begin
    rc_next    = (have_last_q && (in_data == last_q)) ? (rc_q + RW'(1)) : RW'(1);
    ones_total = ones_q + word_ones;
    win_last   = (win_idx_q == WIN_LAST);
    rct_hit    = (rc_next == RCT_LIMIT);
    apt_hit    = win_last && ((ones_total < APT_LO_W) || (ones_total > APT_HI_W));
  end

  // Next-state, handshake and datapath updates; IDLE and any exit to IDLE wipe the test context.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    have_last_d    = have_last_q;
    rc_d           = rc_q;
    win_idx_d      = win_idx_q;
    ones_d         = ones_q;
    win_cnt_d      = win_cnt_q;
    startup_done_d = startup_done_q;
    rct_fail_d     = rct_fail_q;
    apt_fail_d     = apt_fail_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    in_ready       = 1'b0;
    accept         = 1'b0;
    clear_ctx      = 1'b0;

    case (state_q)
      S_IDLE: begin
        clear_ctx = 1'b1;
        if (enable) begin
          state_d = S_STARTUP;
        end
      end

      S_STARTUP, S_RUN: begin
        if (state_q == S_STARTUP) begin
          in_ready = 1'b1;
        end else begin
          in_ready = !out_valid_q || out_ready;
        end
        accept = in_valid && in_ready;

        if (state_q == S_RUN && out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end

        if (!enable) begin
          state_d   = S_IDLE;
          clear_ctx = 1'b1;
        end else if (accept) begin
          have_last_d = 1'b1;
          last_d      = in_data;
          rc_d        = rc_next;
          if (rct_hit || apt_hit) begin
            rct_fail_d  = rct_fail_q | rct_hit;
            apt_fail_d  = apt_fail_q | apt_hit;
            out_valid_d = 1'b0;
            state_d     = S_ALARM;
          end else begin
            if (win_last) begin
              win_idx_d = '0;
              ones_d    = '0;
              if (state_q == S_STARTUP) begin
                win_cnt_d = win_cnt_q + SW'(1);
                if ((win_cnt_q + SW'(1)) == START_WINS) begin
                  state_d        = S_RUN;
                  startup_done_d = 1'b1;
                end
              end
            end else begin
              win_idx_d = win_idx_q + IW'(1);
              ones_d    = ones_total;
            end
            if (state_q == S_RUN) begin
              out_data_d  = in_data;
              out_valid_d = 1'b1;
            end
          end
        end
      end

      S_ALARM: begin
        out_valid_d = 1'b0;
        if (alarm_clr) begin
          rct_fail_d = 1'b0;
          apt_fail_d = 1'b0;
          state_d    = S_IDLE;
          clear_ctx  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clear_ctx) begin
      last_d         = '0;
      have_last_d    = 1'b0;
      rc_d           = '0;
      win_idx_d      = '0;
      ones_d         = '0;
      win_cnt_d      = '0;
      startup_done_d = 1'b0;
      out_valid_d    = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      last_q         <= '0;
      have_last_q    <= 1'b0;
      rc_q           <= '0;
      win_idx_q      <= '0;
      ones_q         <= '0;
      win_cnt_q      <= '0;
      startup_done_q <= 1'b0;
      rct_fail_q     <= 1'b0;
      apt_fail_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      have_last_q    <= have_last_d;
      rc_q           <= rc_d;
      win_idx_q      <= win_idx_d;
      ones_q         <= ones_d;
      win_cnt_q      <= win_cnt_d;
      startup_done_q <= startup_done_d;
      rct_fail_q     <= rct_fail_d;
      apt_fail_q     <= apt_fail_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign startup_done = startup_done_q;
  assign rct_fail     = rct_fail_q;
  assign apt_fail     = apt_fail_q;
  assign alarm        = rct_fail_q | apt_fail_q;

endmodule

// File: tb/tb_trng_health_monitor.sv
// tb_trng_health_monitor
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a queue-based model of the health monitor's rules.
module tb_trng_health_monitor;

  localparam int WIDTH      = 32;
  localparam int RCT_CUTOFF = 4;
  localparam int APT_WORDS  = 16;
  localparam int APT_LO     = 200;
  localparam int APT_HI     = 312;
  localparam int START_WINS = 1;

  localparam int M_IDLE    = 0;
  localparam int M_STARTUP = 1;
  localparam int M_RUN     = 2;
  localparam int M_ALARM   = 3;

  logic             clk;
  logic             rstn;
  logic             enable;
  logic             alarm_clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             startup_done;
  logic             rct_fail;
  logic             apt_fail;
  logic             alarm;

  int n_checks = 0;
  int n_pass   = 0;

  trng_health_monitor #(
    .WIDTH(WIDTH), .RCT_CUTOFF(RCT_CUTOFF), .APT_WORDS(APT_WORDS),
    .APT_LO(APT_LO), .APT_HI(APT_HI), .STARTUP_WINDOWS(START_WINS)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .alarm_clr(alarm_clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .startup_done(startup_done), .rct_fail(rct_fail), .apt_fail(apt_fail),
    .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: current mode, repetition history, window tallies, expected output queue.
  int               m_mode   = M_IDLE;
  logic [WIDTH-1:0] m_last   = '0;
  bit               m_have   = 1'b0;
  int               m_rep    = 0;
  int               m_ones   = 0;
  int               m_nw     = 0;
  int               m_passed = 0;
  bit               m_sdone  = 1'b0;
  bit               m_rct    = 1'b0;
  bit               m_apt    = 1'b0;
  logic [WIDTH-1:0] m_q[$];

  function automatic bit m_ready();
    if (m_mode == M_STARTUP) return 1'b1;
    if (m_mode == M_RUN) return (m_q.size() == 0) || out_ready;
    return 1'b0;
  endfunction

  function automatic void m_reset_ctx();
    m_have   = 1'b0;
    m_last   = '0;
    m_rep    = 0;
    m_ones   = 0;
    m_nw     = 0;
    m_passed = 0;
    m_sdone  = 1'b0;
    m_q.delete();
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  // Reference model: applies the health-test rules to whatever the bench drove this cycle.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = M_IDLE;
      m_rct  = 1'b0;
      m_apt  = 1'b0;
      m_reset_ctx();
    end else begin
      bit acc;
      bit was_run;
      bit rct_bad;
      bit apt_bad;
      acc     = in_valid && m_ready();
      was_run = (m_mode == M_RUN);
      case (m_mode)
        M_IDLE: begin
          m_reset_ctx();
          if (enable) m_mode = M_STARTUP;
        end
        M_STARTUP, M_RUN: begin
          if (was_run && m_q.size() > 0 && out_ready) void'(m_q.pop_front());
          if (!enable) begin
            m_mode = M_IDLE;
            m_reset_ctx();
          end else if (acc) begin
            m_rep  = (m_have && in_data == m_last) ? m_rep + 1 : 1;
            m_last = in_data;
            m_have = 1'b1;
            m_ones += $countones(in_data);
            m_nw++;
            rct_bad = (m_rep >= RCT_CUTOFF);
            apt_bad = (m_nw == APT_WORDS) && (m_ones < APT_LO || m_ones > APT_HI);
            if (rct_bad || apt_bad) begin
              m_rct  = m_rct | rct_bad;
              m_apt  = m_apt | apt_bad;
              m_mode = M_ALARM;
              m_q.delete();
            end else begin
              if (m_nw == APT_WORDS) begin
                m_nw   = 0;
                m_ones = 0;
                if (!was_run) begin
                  m_passed++;
                  if (m_passed == START_WINS) begin
                    m_mode  = M_RUN;
                    m_sdone = 1'b1;
                  end
                end
              end
              if (was_run) m_q.push_back(in_data);
            end
          end
        end
        default: begin
          m_q.delete();
          if (alarm_clr) begin
            m_rct  = 1'b0;
            m_apt  = 1'b0;
            m_mode = M_IDLE;
            m_reset_ctx();
          end
        end
      endcase
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) checkOutput("out_data", out_data, m_q[0]);
    checkOutput("startup_done", {31'b0, startup_done}, {31'b0, m_sdone});
    checkOutput("rct_fail", {31'b0, rct_fail}, {31'b0, m_rct});
    checkOutput("apt_fail", {31'b0, apt_fail}, {31'b0, m_apt});
    checkOutput("alarm", {31'b0, alarm}, {31'b0, m_rct | m_apt});
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doStartup();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i % 2 == 1) ? 32'hFFFF0000 : 32'h0000FFFF, 1'b1);
      tick();
      checkOutput("lit_startup_no_out", {31'b0, out_valid}, 32'd0);
      if (i == 14) checkOutput("lit_startup_early", {31'b0, startup_done}, 32'd0);
    end
    checkOutput("lit_startup_done", {31'b0, startup_done}, 32'd1);
  endtask

  task automatic pulseClear();
    applyStimulus(1'b0, '0, 1'b1);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    checkOutput("lit_clr_alarm", {31'b0, alarm}, 32'd0);
    checkOutput("lit_clr_idle_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("lit_clr_sdone", {31'b0, startup_done}, 32'd0);
    tick();
    checkOutput("lit_clr_restart_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] rct_words [8];
    logic [WIDTH-1:0] bp_words [4];
    logic [WIDTH-1:0] prev;
    rct_words = '{32'hA5A55A5A, 32'hA5A55A5A, 32'hA5A55A5A, 32'h00FF00FF,
                  32'hA5A55A5A, 32'hA5A55A5A, 32'hA5A55A5A, 32'hA5A55A5A};
    bp_words  = '{32'hF0F0F0F0, 32'h33333333, 32'hCCCCCCCC, 32'h55555555};

    rstn = 1'b0; enable = 1'b0; alarm_clr = 1'b0;
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    repeat (3) tick();
    checkOutput("lit_rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("lit_rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("lit_rst_out_data", out_data, 32'd0);
    checkOutput("lit_rst_alarm", {31'b0, alarm}, 32'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    enable = 1'b1;
    tick();
    checkOutput("lit_enable_ready", {31'b0, in_ready}, 32'd1);

    doStartup();
    applyStimulus(1'b1, 32'h12345678, 1'b1);
    tick();
    checkOutput("lit_first_fwd_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("lit_first_fwd_data", out_data, 32'h12345678);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, rct_words[i], 1'b1);
      tick();
      if (i < 7) begin
        checkOutput("lit_rct_fwd", out_data, rct_words[i]);
        checkOutput("lit_rct_nofail", {31'b0, rct_fail}, 32'd0);
      end
    end
    checkOutput("lit_rct_fail", {31'b0, rct_fail}, 32'd1);
    checkOutput("lit_rct_alarm", {31'b0, alarm}, 32'd1);
    checkOutput("lit_rct_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("lit_rct_in_ready", {31'b0, in_ready}, 32'd0);

    applyStimulus(1'b0, '0, 1'b1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    checkOutput("lit_alarm_holds", {31'b0, alarm}, 32'd1);
    checkOutput("lit_alarm_no_ready", {31'b0, in_ready}, 32'd0);

    pulseClear();
    doStartup();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, WIDTH'(i % 2), 1'b1);
      tick();
      if (i < 15) checkOutput("lit_apt_lo_fwd", out_data, WIDTH'(i % 2));
    end
    checkOutput("lit_apt_lo_fail", {31'b0, apt_fail}, 32'd1);
    checkOutput("lit_apt_lo_drop", {31'b0, out_valid}, 32'd0);

    pulseClear();
    doStartup();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i % 2 == 1) ? 32'hFFFFFFFE : 32'hFFFFFFFF, 1'b1);
      tick();
    end
    checkOutput("lit_apt_hi_fail", {31'b0, apt_fail}, 32'd1);
    checkOutput("lit_apt_hi_rct", {31'b0, rct_fail}, 32'd0);

    pulseClear();
    doStartup();
    applyStimulus(1'b1, 32'h0F0F0F0F, 1'b1);
    tick();
    applyStimulus(1'b1, bp_words[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("lit_bp_hold", out_data, 32'h0F0F0F0F);
      checkOutput("lit_bp_ready", {31'b0, in_ready}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, bp_words[i], 1'b1);
      tick();
      checkOutput("lit_bp_stream", out_data, bp_words[i]);
    end
    applyStimulus(1'b0, '0, 1'b1);
    enable = 1'b0;
    tick();
    checkOutput("lit_disable_sdone", {31'b0, startup_done}, 32'd0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i % 2 == 1) ? 32'hFFFF0000 : 32'h0000FFFF, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    doStartup();

    prev = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      logic [WIDTH-1:0] d;
      r = $urandom_range(0, 9);
      if (r < 3) d = prev;
      else if (r == 3) d = $urandom & $urandom & $urandom;
      else d = $urandom;
      prev = d;
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7);
      alarm_clr = (m_mode == M_ALARM) && ($urandom_range(0, 7) == 0);
      enable = 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        enable   = 1'b0;
        in_valid = 1'b0;
      end
      tick();
    end
    alarm_clr = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
